instr_fetch_seq: RTL and testbench
==================================

Name: instr_fetch_seq

Overview:
- Fetch/step sequencer on the consuming side of the PC interface. The PC block produces an address and advances on an active-low step pulse; this block is the consumer of that address.
- On each operator step press it:
  - reads the instruction at the current PC from instruction ROM,
  - latches it into the instruction register and strobes execute,
  - drives the active-low advance pulse back to the PC block.
- It also owns the active-low PC clear.
- Sits between the front-panel step key, the PC block and the instruction ROM.

Parameters:
IW, 16, instruction word width
AW, 8, address width (matches PC width)
LAST_ADDR, 8'h02, last valid program address; asserts last_instr
TIMEOUT, 15, max cycles to wait for rom_ready before abort
ADV_CYCLES, 2, length in clk cycles of the low pc_adv_n pulse

Ports:
clk  in  1  system clock, all logic on rising edge
clr  in  1  synchronous active-high reset
step_n  in  1  raw operator step key, active-low, asynchronous to clk
pc  in  AW  current PC value from PC block
rom_rdata  in  IW  ROM read data, valid when rom_ready=1
rom_ready  in  1  ROM read-complete, single-cycle or held
rom_addr  out  AW  ROM read address
rom_rd  out  1  ROM read request
ir  out  IW  instruction register
ir_valid  out  1  ir holds a successfully fetched word
exec_strobe  out  1  one-cycle pulse: ir just loaded
pc_adv_n  out  1  active-low advance pulse to PC block
pc_clr_n  out  1  active-low PC clear
last_instr  out  1  fetched address equalled LAST_ADDR
fetch_err  out  1  sticky: ROM timeout occurred
busy  out  1  state != IDLE

Behaviour:
- Reset (clr=1 at a clk edge) sets:
  - state=IDLE; rom_addr=0; rom_rd=0; ir=0; ir_valid=0; exec_strobe=0; pc_adv_n=1; last_instr=0; fetch_err=0.
  - Timeout and pulse counters to 0.
  - Synchronizer flops to 1.
- pc_clr_n:
  - Registered; 0 while clr=1 and for exactly one cycle after clr deasserts, then 1.
  - PC therefore reads 0 before the first fetch.
- Reset mid-operation aborts any fetch or advance immediately; pc_adv_n returns to 1 on the same edge.
- step_n input stage:
  - Two-flop synchronizer, then falling-edge detect; this produces the one-cycle internal step.
  - A step is accepted only in IDLE. Steps while busy are dropped, not queued.
- FSM states: IDLE, REQ, WAIT, LOAD, ADV.
- IDLE:
  - On step, capture rom_addr<=pc and assert rom_rd.
  - Set last_instr<=(pc==LAST_ADDR).
  - Clear the timeout counter, then go to REQ.
- REQ: one cycle, rom_rd=1; go to WAIT.
- WAIT:
  - rom_rd held 1. Timeout counter increments each cycle.
  - If rom_ready=1: ir<=rom_rdata, rom_rd<=0, go to LOAD.
  - Else if counter==TIMEOUT: rom_rd<=0, fetch_err<=1, go to IDLE; ir and ir_valid are unchanged and no advance occurs.
  - rom_ready seen in REQ is also accepted, with the same action as in WAIT.
- LOAD:
  - exec_strobe=1 for this cycle only; ir_valid<=1.
  - Go to ADV.
- ADV:
  - pc_adv_n=0 for exactly ADV_CYCLES cycles, then 1; return to IDLE.
  - The PC block performs its own wrap LAST_ADDR->0. This block does not alter pc.
- Latency: step edge on step_n to rom_rd=1 is 3 clk (2 sync + edge register).
- rom_addr is stable from REQ through end of WAIT. It does not track pc changes during a fetch.
- fetch_err clears only on clr.
- busy is 1 in REQ, WAIT, LOAD and ADV.
- Simultaneous events:
  - clr has priority over everything.
  - rom_ready on the same cycle the timeout expires counts as success.

Test Plan:
- Reset: hold clr=1 3 cycles -> pc_clr_n=0 during clr plus 1 cycle; ir=0, ir_valid=0, pc_adv_n=1, busy=0.
- Single fetch: pc=8'h00, ROM[0]=16'hA5C3 with ready 2 cycles after rom_rd, press step_n -> rom_addr=0, ir=16'hA5C3, exec_strobe 1 cycle, pc_adv_n low exactly 2 cycles, last_instr=0.
- Program sweep with a PC model wrapping at 2: 4 presses -> fetched addresses 0,1,2,0; last_instr=1 only on the fetch of address 2.
- Timeout: rom_ready held 0 -> rom_rd drops after 15 WAIT cycles; fetch_err=1; ir unchanged; no pc_adv_n pulse; next press with a working ROM still fetches and fetch_err stays 1.
- Step while busy: second step_n press during WAIT -> ignored; exactly one exec_strobe and one advance pulse.
- Reset mid-ADV: assert clr while pc_adv_n=0 -> pc_adv_n=1 and state IDLE on the next edge; ir_valid=0; pc_clr_n=0.

Source files
------------

// File: rtl/instr_fetch_seq_if.sv
// rtl/instr_fetch_seq_if.sv - instruction ROM read bus between fetch sequencer and ROM
//   rom_addr  : read address (master -> slave)
//   rom_rd    : read request, held until rom_ready or abort (master -> slave)
//   rom_rdata : read data, valid while rom_ready=1 (slave -> master)
//   rom_ready : read complete, single-cycle or held (slave -> master)
interface instr_fetch_seq_if #(
    parameter int AW = 8,
    parameter int IW = 16
);
    logic [AW-1:0] rom_addr;
    logic          rom_rd;
    logic [IW-1:0] rom_rdata;
    logic          rom_ready;

    modport master (
        output rom_addr,
        output rom_rd,
        input  rom_rdata,
        input  rom_ready
    );

    modport slave (
        input  rom_addr,
        input  rom_rd,
        output rom_rdata,
        output rom_ready
    );
endinterface

// File: rtl/instr_fetch_seq.sv
// rtl/instr_fetch_seq.sv - operator-stepped instruction fetch sequencer
//   clk         : system clock, rising edge
//   clr         : synchronous active-high reset
//   step_n      : raw active-low step key, asynchronous
//   pc          : current PC from the PC block
//   rom         : ROM read bus (master side)
//   ir/ir_valid : instruction register and its valid flag
//   exec_strobe : one-cycle pulse when ir has just been loaded
//   pc_adv_n    : active-low advance pulse to the PC block
//   pc_clr_n    : active-low PC clear
//   last_instr  : fetched address equalled LAST_ADDR
//   fetch_err   : sticky ROM timeout flag
//   busy        : sequencer not idle
module instr_fetch_seq #(
    parameter int            IW         = 16,
    parameter int            AW         = 8,
    parameter logic [AW-1:0] LAST_ADDR  = 'h02,
    parameter int            TIMEOUT    = 15,
    parameter int            ADV_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  clr,
    input  logic                  step_n,
    input  logic [AW-1:0]         pc,
    instr_fetch_seq_if.master     rom,
    output logic [IW-1:0]         ir,
    output logic                  ir_valid,
    output logic                  exec_strobe,
    output logic                  pc_adv_n,
    output logic                  pc_clr_n,
    output logic                  last_instr,
    output logic                  fetch_err,
    output logic                  busy
);
    localparam int TW  = $clog2(TIMEOUT + 1);
    localparam int AVW = $clog2(ADV_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_LOAD,
        S_ADV
    } state_t;

    state_t          state_q,       state_d;
    logic [AW-1:0]   rom_addr_q,    rom_addr_d;
    logic            rom_rd_q,      rom_rd_d;
    logic [IW-1:0]   ir_q,          ir_d;
    logic            ir_valid_q,    ir_valid_d;
    logic            exec_strobe_q, exec_strobe_d;
    logic            pc_adv_n_q,    pc_adv_n_d;
    logic            pc_clr_n_q,    pc_clr_n_d;
    logic            last_instr_q,  last_instr_d;
    logic            fetch_err_q,   fetch_err_d;
    logic [TW-1:0]   tmo_cnt_q,     tmo_cnt_d;
    logic [AVW-1:0]  adv_cnt_q,     adv_cnt_d;
    logic            sync1_q,       sync1_d;
    logic            sync2_q,       sync2_d;
    logic            step_prev_q,   step_prev_d;
    logic            clr_hold_q,    clr_hold_d;
    logic            step_pulse;

    always_comb begin
        state_d       = state_q;
        rom_addr_d    = rom_addr_q;
        rom_rd_d      = rom_rd_q;
        ir_d          = ir_q;
        ir_valid_d    = ir_valid_q;
        exec_strobe_d = 1'b0;
        pc_adv_n_d    = pc_adv_n_q;
        last_instr_d  = last_instr_q;
        fetch_err_d   = fetch_err_q;
        tmo_cnt_d     = tmo_cnt_q;
        adv_cnt_d     = adv_cnt_q;

        sync1_d     = step_n;
        sync2_d     = sync1_q;
        step_prev_d = sync2_q;
        // Falling edge of the synchronised key; one cycle wide.
        step_pulse  = step_prev_q & ~sync2_q;

        // Hold the PC clear one extra cycle past clr so the PC block sees it
        // even if it samples clr-derived signals a cycle late.
        clr_hold_d  = clr;
        pc_clr_n_d  = ~(clr | clr_hold_q);

        case (state_q)
            S_IDLE: begin
                if (step_pulse) begin
                    rom_addr_d   = pc;
                    rom_rd_d     = 1'b1;
                    last_instr_d = (pc == LAST_ADDR);
                    tmo_cnt_d    = '0;
                    state_d      = S_REQ;
                end
            end
            S_REQ: begin
                if (rom.rom_ready) begin
                    ir_d          = rom.rom_rdata;
                    rom_rd_d      = 1'b0;
                    exec_strobe_d = 1'b1;
                    state_d       = S_LOAD;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                tmo_cnt_d = tmo_cnt_q + TW'(1);
                // rom_ready wins over an expiring timeout in the same cycle.
                if (rom.rom_ready) begin
                    ir_d          = rom.rom_rdata;
                    rom_rd_d      = 1'b0;
                    exec_strobe_d = 1'b1;
                    state_d       = S_LOAD;
                end else if (tmo_cnt_q == TW'(TIMEOUT - 1)) begin
                    rom_rd_d    = 1'b0;
                    fetch_err_d = 1'b1;
                    state_d     = S_IDLE;
                end
            end
            S_LOAD: begin
                ir_valid_d = 1'b1;
                pc_adv_n_d = 1'b0;
                adv_cnt_d  = '0;
                state_d    = S_ADV;
            end
            S_ADV: begin
                adv_cnt_d = adv_cnt_q + AVW'(1);
                if (adv_cnt_q == AVW'(ADV_CYCLES - 1)) begin
                    pc_adv_n_d = 1'b1;
                    state_d    = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        clr_hold_q <= clr_hold_d;
        pc_clr_n_q <= pc_clr_n_d;
        if (clr) begin
            state_q       <= S_IDLE;
            rom_addr_q    <= '0;
            rom_rd_q      <= 1'b0;
            ir_q          <= '0;
            ir_valid_q    <= 1'b0;
            exec_strobe_q <= 1'b0;
            pc_adv_n_q    <= 1'b1;
            last_instr_q  <= 1'b0;
            fetch_err_q   <= 1'b0;
            tmo_cnt_q     <= '0;
            adv_cnt_q     <= '0;
            sync1_q       <= 1'b1;
            sync2_q       <= 1'b1;
            step_prev_q   <= 1'b1;
        end else begin
            state_q       <= state_d;
            rom_addr_q    <= rom_addr_d;
            rom_rd_q      <= rom_rd_d;
            ir_q          <= ir_d;
            ir_valid_q    <= ir_valid_d;
            exec_strobe_q <= exec_strobe_d;
            pc_adv_n_q    <= pc_adv_n_d;
            last_instr_q  <= last_instr_d;
            fetch_err_q   <= fetch_err_d;
            tmo_cnt_q     <= tmo_cnt_d;
            adv_cnt_q     <= adv_cnt_d;
            sync1_q       <= sync1_d;
            sync2_q       <= sync2_d;
            step_prev_q   <= step_prev_d;
        end
    end

    assign rom.rom_addr = rom_addr_q;
    assign rom.rom_rd   = rom_rd_q;
    assign ir           = ir_q;
    assign ir_valid     = ir_valid_q;
    assign exec_strobe  = exec_strobe_q;
    assign pc_adv_n     = pc_adv_n_q;
    assign pc_clr_n     = pc_clr_n_q;
    assign last_instr   = last_instr_q;
    assign fetch_err    = fetch_err_q;
    assign busy         = (state_q != S_IDLE);
endmodule

// File: tb/tb_instr_fetch_seq.sv
// tb/tb_instr_fetch_seq.sv - randomized self-checking bench for instr_fetch_seq
module tb_instr_fetch_seq;
    localparam logic [7:0] LAST = 8'h02;

    logic        clk = 1'b0;
    logic        clr;
    logic        step_n;
    logic [7:0]  pc;
    logic [15:0] ir;
    logic        ir_valid, exec_strobe, pc_adv_n, pc_clr_n;
    logic        last_instr, fetch_err, busy;

    instr_fetch_seq_if #(.AW(8), .IW(16)) rom_if ();

    instr_fetch_seq #(
        .IW(16), .AW(8), .LAST_ADDR(8'h02), .TIMEOUT(15), .ADV_CYCLES(2)
    ) dut (
        .clk(clk), .clr(clr), .step_n(step_n), .pc(pc), .rom(rom_if.master),
        .ir(ir), .ir_valid(ir_valid), .exec_strobe(exec_strobe),
        .pc_adv_n(pc_adv_n), .pc_clr_n(pc_clr_n), .last_instr(last_instr),
        .fetch_err(fetch_err), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    // ROM model: answers rom_rd after rom_lat negedges, or never when dead.
    logic [15:0] rom_mem [256];
    int          rom_lat  = 2;
    bit          rom_dead = 1'b0;
    int          rom_wait = 0;

    always @(negedge clk) begin
        if (rom_if.rom_rd !== 1'b1 || clr === 1'b1) begin
            rom_if.rom_ready = 1'b0;
            rom_wait = 0;
        end else begin
            rom_wait++;
            if (!rom_dead && rom_wait >= rom_lat) begin
                rom_if.rom_ready = 1'b1;
                rom_if.rom_rdata = rom_mem[rom_if.rom_addr];
            end else begin
                rom_if.rom_ready = 1'b0;
            end
        end
    end

    // PC block model: clears on pc_clr_n, advances with wrap on each pulse.
    logic adv_prev = 1'b1;
    always @(negedge clk) begin
        if (pc_clr_n === 1'b0) pc = 8'h00;
        else if (adv_prev === 1'b1 && pc_adv_n === 1'b0) pc = next_pc(pc);
        adv_prev = pc_adv_n;
    end

    function automatic logic [7:0] next_pc(input logic [7:0] p);
        return (p == LAST) ? 8'h00 : p + 8'h01;
    endfunction

    // Observation of output activity, sampled just after each rising edge.
    int          exec_cnt = 0;
    int          adv_len = 0;
    int          adv_q[$];
    logic [7:0]  addr_q[$];
    logic        last_q[$];
    int          rd_len_q[$];
    int          rd_len = 0;
    bit          rd_prev = 1'b0;
    logic [7:0]  rd_addr;
    int          addr_moves = 0;

    always @(posedge clk) begin
        #1;
        if (exec_strobe === 1'b1) exec_cnt++;
        if (pc_adv_n === 1'b0) adv_len++;
        else if (adv_len > 0) begin adv_q.push_back(adv_len); adv_len = 0; end
        if (rom_if.rom_rd === 1'b1) begin
            if (!rd_prev) begin
                addr_q.push_back(rom_if.rom_addr);
                last_q.push_back(last_instr);
                rd_addr = rom_if.rom_addr;
                rd_len = 0;
            end else if (rom_if.rom_addr !== rd_addr) begin
                addr_moves++;
            end
            rd_len++;
            rd_prev = 1'b1;
        end else begin
            if (rd_prev) rd_len_q.push_back(rd_len);
            rd_prev = 1'b0;
        end
    end

    task automatic clear_mon;
        exec_cnt = 0;
        adv_q.delete();
        addr_q.delete();
        last_q.delete();
        rd_len_q.delete();
        addr_moves = 0;
    endtask

    task automatic do_reset;
        @(negedge clk);
        clr = 1'b1;
        step_n = 1'b1;
        rom_dead = 1'b0;
        repeat (3) @(negedge clk);
        clr = 1'b0;
        repeat (3) @(negedge clk);
        clear_mon();
    endtask

    task automatic press_and_wait(output bit ok);
        int n;
        ok = 1'b1;
        @(negedge clk);
        step_n = 1'b0;
        n = 0;
        while (busy !== 1'b1 && n < 10) begin @(posedge clk); #1; n++; end
        if (busy !== 1'b1) ok = 1'b0;
        @(negedge clk);
        step_n = 1'b1;
        n = 0;
        while (busy === 1'b1 && n < 200) begin @(posedge clk); #1; n++; end
        if (busy !== 1'b0) ok = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset;
        @(negedge clk);
        clr = 1'b1;
        step_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            n_total++;
            if (pc_clr_n !== 1'b0) $display("FAIL reset_pc_clr_n[%0d]: got %b expected 0", i, pc_clr_n);
            else n_pass++;
        end
        n_total++;
        if ({ir, ir_valid, pc_adv_n, busy} !== {16'h0000, 1'b0, 1'b1, 1'b0})
            $display("FAIL reset_outputs: ir=%h ir_valid=%b pc_adv_n=%b busy=%b expected 0000 0 1 0",
                     ir, ir_valid, pc_adv_n, busy);
        else n_pass++;
        n_total++;
        if ({rom_if.rom_rd, exec_strobe, last_instr, fetch_err, rom_if.rom_addr} !== 12'h000)
            $display("FAIL reset_misc: rom_rd=%b exec=%b last=%b err=%b addr=%h expected all 0",
                     rom_if.rom_rd, exec_strobe, last_instr, fetch_err, rom_if.rom_addr);
        else n_pass++;
        @(negedge clk);
        clr = 1'b0;
        @(posedge clk); #1;
        n_total++;
        if (pc_clr_n !== 1'b0) $display("FAIL reset_pc_clr_hold: got %b expected 0", pc_clr_n);
        else n_pass++;
        @(posedge clk); #1;
        n_total++;
        if (pc_clr_n !== 1'b1) $display("FAIL reset_pc_clr_release: got %b expected 1", pc_clr_n);
        else n_pass++;
        @(negedge clk);
        n_total++;
        if (pc !== 8'h00) $display("FAIL reset_pc_model: got %h expected 00", pc);
        else n_pass++;
    endtask

    task automatic test_single_fetch;
        int n;
        do_reset();
        rom_mem[0] = 16'hA5C3;
        rom_lat = 2;
        @(negedge clk);
        step_n = 1'b0;
        n = 0;
        while (rom_if.rom_rd !== 1'b1 && n < 10) begin @(posedge clk); #1; n++; end
        n_total++;
        if (n !== 3) $display("FAIL single_latency: got %0d cycles expected 3", n);
        else n_pass++;
        @(negedge clk);
        step_n = 1'b1;
        n = 0;
        while (busy === 1'b1 && n < 100) begin @(posedge clk); #1; n++; end
        @(negedge clk);
        n_total++;
        if (busy !== 1'b0) $display("FAIL single_done: busy=%b expected 0", busy);
        else n_pass++;
        n_total++;
        if (addr_q.size() !== 1 || addr_q[0] !== 8'h00)
            $display("FAIL single_addr: fetches=%0d addr=%h expected 1 fetch of 00",
                     addr_q.size(), (addr_q.size() > 0) ? addr_q[0] : 8'hxx);
        else n_pass++;
        n_total++;
        if (ir !== 16'hA5C3 || ir_valid !== 1'b1)
            $display("FAIL single_ir: ir=%h valid=%b expected a5c3 1", ir, ir_valid);
        else n_pass++;
        n_total++;
        if (exec_cnt !== 1) $display("FAIL single_exec: got %0d strobe cycles expected 1", exec_cnt);
        else n_pass++;
        n_total++;
        if (adv_q.size() !== 1 || adv_q[0] !== 2)
            $display("FAIL single_adv: pulses=%0d len=%0d expected 1 pulse of 2",
                     adv_q.size(), (adv_q.size() > 0) ? adv_q[0] : -1);
        else n_pass++;
        n_total++;
        if (last_instr !== 1'b0) $display("FAIL single_last: got %b expected 0", last_instr);
        else n_pass++;
        n_total++;
        if (pc !== 8'h01) $display("FAIL single_pc: got %h expected 01", pc);
        else n_pass++;
    endtask

    task automatic test_program_sweep;
        logic [7:0] exp_addr;
        bit ok;
        do_reset();
        for (int a = 0; a < 256; a++) rom_mem[a] = 16'($urandom);
        exp_addr = 8'h00;
        for (int i = 0; i < 7; i++) begin
            rom_lat = $urandom_range(1, 6);
            clear_mon();
            press_and_wait(ok);
            n_total++;
            if (!ok) $display("FAIL sweep_handshake[%0d]: busy did not cycle expected one fetch", i);
            else n_pass++;
            n_total++;
            if (addr_q.size() !== 1 || addr_q[0] !== exp_addr)
                $display("FAIL sweep_addr[%0d]: fetches=%0d addr=%h expected 1 fetch of %h", i,
                         addr_q.size(), (addr_q.size() > 0) ? addr_q[0] : 8'hxx, exp_addr);
            else n_pass++;
            n_total++;
            if (ir !== rom_mem[exp_addr])
                $display("FAIL sweep_ir[%0d]: got %h expected %h", i, ir, rom_mem[exp_addr]);
            else n_pass++;
            n_total++;
            if (last_q.size() !== 1 || last_q[0] !== (exp_addr == LAST))
                $display("FAIL sweep_last[%0d]: got %b expected %b", i,
                         (last_q.size() > 0) ? last_q[0] : 1'bx, (exp_addr == LAST));
            else n_pass++;
            n_total++;
            if (exec_cnt !== 1 || adv_q.size() !== 1 || adv_q[0] !== 2)
                $display("FAIL sweep_exec_adv[%0d]: strobes=%0d pulses=%0d expected 1 and 1x2", i,
                         exec_cnt, adv_q.size());
            else n_pass++;
            exp_addr = next_pc(exp_addr);
        end
    endtask

    task automatic test_timeout;
        logic [15:0] ir_before;
        logic [7:0]  pc_before;
        bit ok;
        do_reset();
        rom_lat = 3;
        press_and_wait(ok);
        rom_dead = 1'b1;
        ir_before = ir;
        pc_before = pc;
        clear_mon();
        press_and_wait(ok);
        n_total++;
        if (rd_len_q.size() !== 1 || rd_len_q[0] !== 16)
            $display("FAIL timeout_rd_len: got %0d cycles expected 16 (REQ + 15 WAIT)",
                     (rd_len_q.size() > 0) ? rd_len_q[0] : -1);
        else n_pass++;
        n_total++;
        if (fetch_err !== 1'b1) $display("FAIL timeout_err: got %b expected 1", fetch_err);
        else n_pass++;
        n_total++;
        if (ir !== ir_before || ir_valid !== 1'b1)
            $display("FAIL timeout_ir: ir=%h valid=%b expected %h 1", ir, ir_valid, ir_before);
        else n_pass++;
        n_total++;
        if (exec_cnt !== 0 || adv_q.size() !== 0 || pc !== pc_before)
            $display("FAIL timeout_no_adv: strobes=%0d pulses=%0d pc=%h expected 0 0 %h",
                     exec_cnt, adv_q.size(), pc, pc_before);
        else n_pass++;

        // rom_ready arriving on the last WAIT cycle still counts as success.
        rom_dead = 1'b0;
        rom_lat = 16;
        clear_mon();
        press_and_wait(ok);
        n_total++;
        if (ir !== rom_mem[pc_before] || exec_cnt !== 1)
            $display("FAIL timeout_edge_ok: ir=%h strobes=%0d expected %h 1", ir, exec_cnt,
                     rom_mem[pc_before]);
        else n_pass++;
        n_total++;
        if (fetch_err !== 1'b1) $display("FAIL timeout_err_sticky: got %b expected 1", fetch_err);
        else n_pass++;

        // One cycle later is too late.
        rom_lat = 17;
        ir_before = ir;
        pc_before = pc;
        clear_mon();
        press_and_wait(ok);
        n_total++;
        if (exec_cnt !== 0 || ir !== ir_before || pc !== pc_before)
            $display("FAIL timeout_edge_late: strobes=%0d ir=%h pc=%h expected 0 %h %h",
                     exec_cnt, ir, pc, ir_before, pc_before);
        else n_pass++;
    endtask

    task automatic test_step_while_busy;
        logic [7:0] pc_before;
        int n;
        do_reset();
        rom_lat = 8;
        pc_before = pc;
        clear_mon();
        @(negedge clk);
        step_n = 1'b0;
        n = 0;
        while (rom_if.rom_rd !== 1'b1 && n < 10) begin @(posedge clk); #1; n++; end
        @(negedge clk);
        step_n = 1'b1;
        repeat (2) @(negedge clk);
        step_n = 1'b0;
        pc = 8'hEE;
        repeat (2) @(negedge clk);
        pc = pc_before;
        repeat (2) @(negedge clk);
        step_n = 1'b1;
        n = 0;
        while (busy === 1'b1 && n < 100) begin @(posedge clk); #1; n++; end
        repeat (10) @(negedge clk);
        n_total++;
        if (exec_cnt !== 1 || adv_q.size() !== 1 || addr_q.size() !== 1)
            $display("FAIL busy_drop: strobes=%0d pulses=%0d fetches=%0d expected 1 1 1",
                     exec_cnt, adv_q.size(), addr_q.size());
        else n_pass++;
        n_total++;
        if (pc !== next_pc(pc_before) || busy !== 1'b0)
            $display("FAIL busy_pc: pc=%h busy=%b expected %h 0", pc, busy, next_pc(pc_before));
        else n_pass++;
        n_total++;
        if (addr_moves !== 0 || ir !== rom_mem[pc_before])
            $display("FAIL busy_addr_stable: moves=%0d ir=%h expected 0 %h", addr_moves, ir,
                     rom_mem[pc_before]);
        else n_pass++;
    endtask

    task automatic test_reset_mid_adv;
        int n;
        do_reset();
        rom_lat = 2;
        @(negedge clk);
        step_n = 1'b0;
        n = 0;
        while (pc_adv_n !== 1'b0 && n < 40) begin @(posedge clk); #1; n++; end
        n_total++;
        if (pc_adv_n !== 1'b0) $display("FAIL midadv_reach: pc_adv_n=%b expected 0", pc_adv_n);
        else n_pass++;
        @(negedge clk);
        clr = 1'b1;
        step_n = 1'b1;
        @(posedge clk); #1;
        n_total++;
        if ({pc_adv_n, busy, ir_valid, pc_clr_n} !== 4'b1000)
            $display("FAIL midadv_abort: pc_adv_n=%b busy=%b ir_valid=%b pc_clr_n=%b expected 1 0 0 0",
                     pc_adv_n, busy, ir_valid, pc_clr_n);
        else n_pass++;
        @(negedge clk);
        clr = 1'b0;
        repeat (3) @(negedge clk);
        n_total++;
        if (pc !== 8'h00 || pc_clr_n !== 1'b1)
            $display("FAIL midadv_recover: pc=%h pc_clr_n=%b expected 00 1", pc, pc_clr_n);
        else n_pass++;
    endtask

    initial begin
        clr = 1'b1;
        step_n = 1'b1;
        pc = 8'h00;
        rom_if.rom_ready = 1'b0;
        rom_if.rom_rdata = 16'h0000;
        for (int a = 0; a < 256; a++) rom_mem[a] = 16'($urandom);
        repeat (2) @(negedge clk);
        test_reset();
        test_single_fetch();
        test_program_sweep();
        test_timeout();
        test_step_while_busy();
        test_reset_mid_adv();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation exceeded time bound");
        $fatal(1);
    end
endmodule
